// File: rtl/intc_pkg.sv
// Shared types and constants for the vectored interrupt controller.
// Holds the sequencer state encoding, the injected NOOP word and the ID-width helper.
package intc_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] INSTR_NOOP = 32'h7800_0000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FLUSH,
    JUMP,
    SVC
  } state_t;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter  int N    = 8,
  localparam int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scanning from the top down lets the lowest set index overwrite the rest.
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/vectored_interrupt_controller.sv
// Latches edge/level interrupt requests, arbitrates by fixed priority and, once accepted,
// injects a NOOP flush followed by a jump to the channel's vector into the fetch stream.
module vectored_interrupt_controller
  import intc_pkg::*;
#(
  parameter  int                   NUM_IRQ    = 8,
  parameter  int                   NUM_FLUSH  = 5,
  parameter  logic [INSTR_W-1:0]   VEC_BASE   = 32'hA000_0000,
  parameter  int                   VEC_STRIDE = 2,
  parameter  logic [NUM_IRQ-1:0]   EDGE_MASK  = '1,
  localparam int                   ID_W       = id_width(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] IO,
  input  logic [NUM_IRQ-1:0] IMR_in,
  input  logic               ACK,
  output logic               INT,
  output logic [INSTR_W-1:0] INT_INSTR,
  output logic               INJ_VALID,
  output logic [ID_W-1:0]    ACTIVE_ID,
  output logic [NUM_IRQ-1:0] PENDING
);

  localparam int CNT_W      = id_width(NUM_FLUSH + 1);
  localparam int FLUSH_LAST = (NUM_FLUSH > 0) ? NUM_FLUSH - 1 : 0;

  state_t             state_reg, state_next;
  logic [NUM_IRQ-1:0] io_q_reg;
  logic [NUM_IRQ-1:0] pending_reg, pending_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               int_reg, int_next;
  logic               inj_reg, inj_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic [ID_W-1:0]    id_reg, id_next;

  logic [NUM_IRQ-1:0] set_vec, clr_vec;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic [INSTR_W-1:0] vector;

  // Edge channels fire on a 0->1 transition, level channels whenever the line is high.
  assign set_vec = (IO & ~io_q_reg & EDGE_MASK) | (IO & ~EDGE_MASK);
  assign vector  = VEC_BASE + INSTR_W'(id_reg) * INSTR_W'(VEC_STRIDE);

  intc_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req   (pending_reg & IMR_in),
    .valid (win_valid),
    .id    (win_id)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    int_next   = int_reg;
    id_next    = id_reg;
    inj_next   = 1'b0;
    instr_next = INSTR_NOOP;
    clr_vec    = '0;
    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          id_next    = win_id;
          int_next   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ACK) begin
          clr_vec  = NUM_IRQ'(1) << id_reg;
          cnt_next = '0;
          inj_next = 1'b1;
          if (NUM_FLUSH == 0) begin
            state_next = JUMP;
            instr_next = vector;
          end else begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        inj_next = 1'b1;
        if (cnt_reg == CNT_W'(FLUSH_LAST)) begin
          state_next = JUMP;
          instr_next = vector;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      JUMP: state_next = SVC;
      SVC: begin
        if (ACK) begin
          int_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A new capture on the channel being cleared wins over the clear.
    pending_next = (pending_reg & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      io_q_reg    <= '0;
      pending_reg <= '0;
      cnt_reg     <= '0;
      int_reg     <= 1'b0;
      inj_reg     <= 1'b0;
      instr_reg   <= INSTR_NOOP;
      id_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      io_q_reg    <= IO;
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
      int_reg     <= int_next;
      inj_reg     <= inj_next;
      instr_reg   <= instr_next;
      id_reg      <= id_next;
    end
  end

  assign INT       = int_reg;
  assign INJ_VALID = inj_reg;
  assign INT_INSTR = instr_reg;
  assign ACTIVE_ID = id_reg;
  assign PENDING   = pending_reg;

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Bench for the vectored interrupt controller: two configurations checked every cycle
// against a transaction-level reference model, plus directed scenario checks.
module tb_vectored_interrupt_controller;

  localparam logic [31:0] NOOP = 32'h7800_0000;
  localparam logic [31:0] BASE = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  io_a, imr_a, pend_a;
  logic [15:0] io_b, imr_b, pend_b;
  logic        ack_a, ack_b, int_a, int_b, inj_a, inj_b;
  logic [31:0] instr_a, instr_b;
  logic [2:0]  id_a;
  logic [3:0]  id_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vectored_interrupt_controller dut_a (
    .clk(clk), .rst_n(rst_n), .IO(io_a), .IMR_in(imr_a), .ACK(ack_a),
    .INT(int_a), .INT_INSTR(instr_a), .INJ_VALID(inj_a), .ACTIVE_ID(id_a), .PENDING(pend_a)
  );

  vectored_interrupt_controller #(
    .NUM_IRQ(16), .NUM_FLUSH(0), .EDGE_MASK(16'h0000)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .IO(io_b), .IMR_in(imr_b), .ACK(ack_b),
    .INT(int_b), .INT_INSTR(instr_b), .INJ_VALID(inj_b), .ACTIVE_ID(id_b), .PENDING(pend_b)
  );

  // Reference model: intr = interrupt outstanding, age = cycles since accept (-1 = not yet).
  typedef struct {
    logic [15:0] pend;
    logic [15:0] ioq;
    bit          intr;
    int          id;
    int          age;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t mstep(input mstate_t s, input logic rst, input logic [15:0] io,
                                    input logic [15:0] imr, input logic ack, input int n,
                                    input int nf, input logic [15:0] em);
    mstate_t r = s;
    logic [15:0] set = '0, clr = '0, act;
    if (!rst) begin
      r.pend = '0; r.ioq = '0; r.intr = 0; r.id = 0; r.age = -1;
      return r;
    end
    for (int i = 0; i < n; i++) set[i] = em[i] ? (io[i] & ~s.ioq[i]) : io[i];
    if (s.intr && s.age < 0) begin
      if (ack) begin clr[s.id] = 1'b1; r.age = 0; end
    end else if (s.intr) begin
      if (s.age > nf) begin
        if (ack) begin r.intr = 0; r.age = -1; end
      end else begin
        r.age = s.age + 1;
      end
    end else begin
      act = s.pend & imr;
      for (int i = 0; i < n; i++) begin
        if (act[i]) begin r.intr = 1; r.age = -1; r.id = i; break; end
      end
    end
    r.pend = (s.pend & ~clr) | set;
    r.ioq  = io;
    return r;
  endfunction

  function automatic logic m_inj(input mstate_t s, input int nf);
    return s.intr && s.age >= 0 && s.age <= nf;
  endfunction

  function automatic logic [31:0] m_instr(input mstate_t s, input int nf);
    if (m_inj(s, nf) && s.age == nf) return BASE + 32'(s.id) * 32'd2;
    return NOOP;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ma = mstep(ma, rst_n, {8'h00, io_a}, {8'h00, imr_a}, ack_a, 8, 5, 16'h00FF);
    mb = mstep(mb, rst_n, io_b, imr_b, ack_b, 16, 0, 16'h0000);
    #1;
    check_val("a_int",   32'(int_a),   32'(ma.intr));
    check_val("a_inj",   32'(inj_a),   32'(m_inj(ma, 5)));
    check_val("a_instr", instr_a,      m_instr(ma, 5));
    check_val("a_id",    32'(id_a),    32'(ma.id));
    check_val("a_pend",  32'(pend_a),  32'(ma.pend[7:0]));
    check_val("b_int",   32'(int_b),   32'(mb.intr));
    check_val("b_inj",   32'(inj_b),   32'(m_inj(mb, 0)));
    check_val("b_instr", instr_b,      m_instr(mb, 0));
    check_val("b_id",    32'(id_b),    32'(mb.id));
    check_val("b_pend",  32'(pend_b),  32'(mb.pend));
  endtask

  task automatic ack_a_pulse();
    ack_a = 1'b1; tick(); ack_a = 1'b0;
  endtask

  initial begin
    int injn, jumps;
    logic [7:0] tmp8;
    ma = '{pend: '0, ioq: '0, intr: 0, id: 0, age: -1};
    mb = ma;
    rst_n = 1'b0; io_a = '0; imr_a = 8'hFF; ack_a = 1'b0;
    io_b = '0; imr_b = 16'hFFFF; ack_b = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check_val("rst_int", 32'(int_a), 32'd0);
    check_val("rst_instr", instr_a, NOOP);
    check_val("rst_pend", 32'(pend_a), 32'd0);
    tick();

    // Single channel service
    for (int i = 0; i < 8; i++) begin
      tmp8 = 8'd1 << i;
      io_a = tmp8; tick(); io_a = '0; tick(); tick();
      check_val("s1_int", 32'(int_a), 32'd1);
      ack_a_pulse();
      injn = 0;
      for (int k = 0; k < 6; k++) begin
        if (k > 0) tick();
        if (inj_a) injn++;
      end
      check_val("s1_jump", instr_a, BASE + 32'(2 * i));
      tick();
      check_val("s1_injcnt", 32'(injn), 32'd6);
      ack_a_pulse();
      check_val("s1_eoi", 32'(int_a), 32'd0);
      tick();
    end

    // Priority order 0, 2, 4
    io_a = 8'h15; tick(); io_a = '0;
    for (int c = 0; c < 5; c += 2) begin
      tick(); tick();
      check_val("s2_id", 32'(id_a), 32'(c));
      ack_a_pulse();
      if (c == 0) check_val("s2_pend", 32'(pend_a), 32'h14);
      for (int k = 0; k < 7; k++) tick();
      ack_a_pulse();
      tick();
    end

    // Masked channel latches but waits
    imr_a = 8'hFE; io_a = 8'h01; tick(); io_a = '0; tick(); tick();
    check_val("s3_int_masked", 32'(int_a), 32'd0);
    check_val("s3_pend0", 32'(pend_a[0]), 32'd1);
    imr_a = 8'hFF; tick(); tick();
    check_val("s3_int", 32'(int_a), 32'd1);
    ack_a_pulse();
    for (int k = 0; k < 5; k++) tick();
    check_val("s3_jump", instr_a, BASE);
    tick(); ack_a_pulse(); tick();

    // Reset during flush
    io_a = 8'h02; tick(); io_a = '0; tick(); tick();
    ack_a_pulse(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_val("s4_int", 32'(int_a), 32'd0);
    check_val("s4_inj", 32'(inj_a), 32'd0);
    check_val("s4_instr", instr_a, NOOP);
    check_val("s4_pend", 32'(pend_a), 32'd0);
    tick();

    // Level channel, zero flush (dut_b)
    io_b = 16'h8000; tick(); tick();
    check_val("s5_int", 32'(int_b), 32'd1);
    ack_b = 1'b1; tick(); ack_b = 1'b0;
    check_val("s5_jump", instr_b, 32'hA000_001E);
    check_val("s5_inj", 32'(inj_b), 32'd1);
    tick();
    ack_b = 1'b1; tick(); ack_b = 1'b0;
    check_val("s5_eoi", 32'(int_b), 32'd0);
    tick();
    check_val("s5_reenter", 32'(int_b), 32'd1);
    io_b = '0; ack_b = 1'b1; tick(); ack_b = 1'b0;
    tick(); tick(); tick();
    ack_b = 1'b1; tick(); ack_b = 1'b0; tick();

    // Re-trigger during service
    io_a = 8'h08; tick(); io_a = '0; tick(); tick();
    ack_a_pulse();
    for (int k = 0; k < 6; k++) tick();
    io_a = 8'h08; tick(); io_a = '0; tick();
    ack_a_pulse(); tick(); tick();
    check_val("s6_reint", 32'(int_a), 32'd1);
    check_val("s6_reid", 32'(id_a), 32'd3);
    ack_a_pulse();
    for (int k = 0; k < 7; k++) tick();
    ack_a_pulse(); tick();

    // ACK held through a full sequence
    ack_a = 1'b1; io_a = 8'h20; tick(); io_a = '0;
    jumps = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (instr_a !== NOOP) jumps++;
    end
    ack_a = 1'b0;
    check_val("s6_jumps", 32'(jumps), 32'd1);
    check_val("s6_hold_int", 32'(int_a), 32'd0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      io_a  = 8'($urandom & $urandom & $urandom);
      ack_a = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) imr_a = 8'($urandom | $urandom);
      io_b  = 16'($urandom & $urandom & $urandom);
      ack_b = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) imr_b = 16'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; io_a = '0; io_b = '0; ack_a = 1'b0; ack_b = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
